// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
// Slice sizing, configuration check and per-stage flag bundle.
package adder_pkg;

    // Width of the operand slice rippled by each pipeline stage.
    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

    // Legal configurations split the operands into equal, non-empty slices.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && (width % stages == 0);
    endfunction

    // Control/sign part of a stage register; the data part is width-dependent.
    typedef struct packed {
        logic valid;
        logic carry;
        logic a_msb;
        logic b_msb;
    } stage_flags_t;

endpackage

// File: rtl/rca_slice.sv
// Combinational CHUNK-bit ripple-carry adder.
// One full adder per bit, carry chained LSB to MSB.
module rca_slice
    import adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]     = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end

    assign co = w_c[CHUNK];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor, one slice per stage.
// Valid/ready flow control with combinational ready back-propagation.
module pipelined_addsub
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $fatal(1, "pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    typedef struct packed {
        stage_flags_t     f;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] pa;
        logic [WIDTH-1:0] pb;
    } stage_t;

    logic [STAGES-1:0] w_adv;
    logic [WIDTH-1:0]  w_b_eff;
    logic              w_cin_eff;

    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub | cin;
    assign in_ready  = !rst && w_adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t           r_q;
        logic [WIDTH-1:0] w_pa_in;
        logic [WIDTH-1:0] w_pb_in;
        logic [WIDTH-1:0] w_sum_in;
        logic [WIDTH-1:0] w_sum_next;
        logic [CHUNK-1:0] w_s;
        logic             w_ci;
        logic             w_co;
        logic             w_v_in;
        logic             w_am;
        logic             w_bm;

        if (k == 0) begin : g_first
            assign w_pa_in  = a;
            assign w_pb_in  = w_b_eff;
            assign w_sum_in = '0;
            assign w_ci     = w_cin_eff;
            assign w_v_in   = in_valid;
            assign w_am     = a[WIDTH-1];
            assign w_bm     = w_b_eff[WIDTH-1];
        end else begin : g_next
            assign w_pa_in  = g_stage[k-1].r_q.pa;
            assign w_pb_in  = g_stage[k-1].r_q.pb;
            assign w_sum_in = g_stage[k-1].r_q.sum;
            assign w_ci     = g_stage[k-1].r_q.f.carry;
            assign w_v_in   = g_stage[k-1].r_q.f.valid;
            assign w_am     = g_stage[k-1].r_q.f.a_msb;
            assign w_bm     = g_stage[k-1].r_q.f.b_msb;
        end

        if (k == STAGES - 1) begin : g_adv_last
            assign w_adv[k] = !r_q.f.valid || out_ready;
        end else begin : g_adv_mid
            assign w_adv[k] = !r_q.f.valid || w_adv[k+1];
        end

        rca_slice #(
            .CHUNK(CHUNK)
        ) u_slice (
            .x (w_pa_in[CHUNK-1:0]),
            .y (w_pb_in[CHUNK-1:0]),
            .ci(w_ci),
            .s (w_s),
            .co(w_co)
        );

        // Merge this stage's slice into the partial sum.
        always_comb begin
            w_sum_next = w_sum_in;
            w_sum_next[k*CHUNK +: CHUNK] = w_s;
        end

        // Stage register: load on advance, cleared by reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q <= '0;
            end else if (w_adv[k]) begin
                r_q.f.valid <= w_v_in;
                r_q.f.carry <= w_co;
                r_q.f.a_msb <= w_am;
                r_q.f.b_msb <= w_bm;
                r_q.sum     <= w_sum_next;
                r_q.pa      <= w_pa_in >> CHUNK;
                r_q.pb      <= w_pb_in >> CHUNK;
            end
        end
    end

    stage_t w_last;
    logic   w_unused_pending;

    assign w_last           = g_stage[STAGES-1].r_q;
    assign w_unused_pending = ^{w_last.pa, w_last.pb};

    assign out_valid = w_last.f.valid;
    assign sum       = w_last.sum;
    assign cout      = w_last.f.carry;
    assign ovf       = (w_last.f.a_msb == w_last.f.b_msb) &&
                       (w_last.sum[WIDTH-1] != w_last.f.a_msb);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=8, STAGES=2).
// Stimulus pushes expected results; a monitor pops and compares.
module tb_pipelined_addsub;

    localparam int W = 8;
    localparam int S = 2;
    localparam longint M = longint'(1) << W;
    localparam longint H = M / 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    pipelined_addsub #(
        .WIDTH (W),
        .STAGES(S)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   lat_mode = 0;
    bit   rdy_rand = 0;

    task automatic chk(input bit ok, input string name,
                       input longint act, input longint req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb,
                                   input int c, input bit l);
        exp_t   e;
        longint ux, uy, sx, sy, r, sr;
        ux = longint'(x);
        uy = longint'(y);
        sx = (ux >= H) ? ux - M : ux;
        sy = (uy >= H) ? uy - M : uy;
        if (sb) begin
            r    = ux - uy;
            e.co = (ux >= uy);
            sr   = sx - sy;
        end else begin
            r    = ux + uy + longint'(ci);
            e.co = (r >= M);
            sr   = sx + sy + longint'(ci);
        end
        e.s   = r[W-1:0];
        e.ov  = (sr > H - 1) || (sr < -H);
        e.cyc = c;
        e.lat = l;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end

    // Accepted beats: record what the result must be.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready)
            q.push_back(model(a, b, cin, sub, cyc, lat_mode));
    end

    bit           prev_stall = 0;
    logic [W+1:0] prev_out;

    // Output monitor: ordering, values, stall hold and latency.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall)
                chk(out_valid && {cout, ovf, sum} == prev_out, "hold",
                    {out_valid, cout, ovf, sum}, {1'b1, prev_out});
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk(0, "unexpected_out", sum, 0);
                end else begin
                    e = q.pop_front();
                    chk(sum == e.s, "sum", sum, e.s);
                    chk(cout == e.co, "cout", cout, e.co);
                    chk(ovf == e.ov, "ovf", ovf, e.ov);
                    if (e.lat && lat_mode)
                        chk(cyc - e.cyc == S, "latency", cyc - e.cyc, S);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {cout, ovf, sum};
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sb);
        bit acc = 0;
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = ci;
        sub = sb;
        for (int t = 0; t < 500 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) chk(0, "send_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(posedge clk);
            #1;
            done = (q.size() == 0) && !out_valid;
        end
        chk(done, "drain", q.size(), 0);
    endtask

    logic [W-1:0] edge_a[8] = '{8'hFF, 8'h80, 8'h80, 8'h00, 8'hFF, 8'h80, 8'h00, 8'h7F};
    logic [W-1:0] edge_b[8] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'hFF, 8'h80, 8'h80, 8'h80};
    logic         edge_c[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic         edge_s[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int start;
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        out_ready = 1'b0;
        #3;
        chk(in_ready == 1'b0, "rst_in_ready", in_ready, 0);
        chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        chk({sum, cout, ovf} == '0, "rst_outputs", {sum, cout, ovf}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk(in_ready == 1'b1, "ready_after_rst", in_ready, 1);

        out_ready = 1'b1;
        send(8'd200, 8'd55, 1'b0, 1'b0);
        send(8'd255, 8'd1, 1'b0, 1'b0);
        send(8'h7F, 8'h01, 1'b0, 1'b0);
        send(8'd5, 8'd7, 1'b1, 1'b1);
        send(8'd7, 8'd5, 1'b0, 1'b1);
        drain();

        out_ready = 1'b0;
        send(8'd10, 8'd20, 1'b0, 1'b0);
        send(8'd30, 8'd40, 1'b1, 1'b0);
        in_valid = 1'b1;
        a = 8'd50;
        b = 8'd60;
        cin = 1'b0;
        sub = 1'b1;
        @(negedge clk);
        chk(in_ready == 1'b0, "full_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk(in_ready == 1'b1, "full_passthru", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send(8'd70, 8'd80, 1'b1, 1'b0);
        drain();

        out_ready = 1'b0;
        send(8'd1, 8'd2, 1'b0, 1'b0);
        send(8'd3, 8'd4, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk(out_valid == 1'b1, "pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        q.delete();
        #1;
        chk(out_valid == 1'b0, "midrst_valid", out_valid, 0);
        chk(sum == '0, "midrst_sum", sum, 0);
        chk(in_ready == 1'b0, "midrst_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk(out_valid == 1'b0, "no_stale", out_valid, 0);
        send(8'd100, 8'd27, 1'b1, 1'b0);
        drain();

        lat_mode = 1;
        start = cyc;
        for (int i = 0; i < 20; i++)
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        chk(cyc - start == 20, "throughput", cyc - start, 20);
        drain();
        lat_mode = 0;

        for (int i = 0; i < 8; i++)
            send(edge_a[i], edge_b[i], edge_c[i], edge_s[i]);
        drain();

        rdy_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        drain();
        rdy_rand = 0;
        out_ready = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
